// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// largest operand width the adder may be built with.
package adder_pkg;

  localparam int WIDTH_MAX = 64;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the bit-serial adder; the requester drives the
// operands and start, the adder returns handshake status and the result.
interface serial_adder_if #(parameter int WIDTH = 8);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, cin,
    input  ready, busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b, cin,
    output ready, busy, done, sum, cout, overflow
  );

endinterface

// File: rtl/fa_cell.sv
// One-bit combinational full adder, reused by the serial adder for every
// bit position.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: a + b + cin computed LSB first, one bit per clock,
// through a single full-adder cell and a carry flop.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  serial_adder_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  generate
    if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("serial_adder: WIDTH must be in 1..%0d", WIDTH_MAX);
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] psum_next;
  logic             cell_s;
  logic             cell_cout;
  logic             accept;
  logic             run;
  logic             last;

  fa_cell u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (cell_s),
    .cout (cell_cout)
  );

  assign accept = bus.start && (state == IDLE || state == DONE);
  assign run    = (state == RUN);
  assign last   = (cnt == CW'(WIDTH - 1));

  // The partial sum only needs to hold bits already produced, so it is one
  // bit narrower than the result; the current cell output completes it.
  generate
    if (WIDTH == 1) begin : g_w1
      assign psum_next = cell_s;
    end else begin : g_wn
      logic [WIDTH-2:0] psum;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          psum <= '0;
        end else if (accept) begin
          psum <= '0;
        end else if (run) begin
          psum <= psum_next[WIDTH-1:1];
        end
      end

      assign psum_next = {cell_s, psum};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, DONE: state <= bus.start ? RUN : IDLE;
        RUN:        if (last) state <= DONE;
        default:    state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      a_sh  <= bus.a;
      b_sh  <= bus.b;
      carry <= bus.cin;
      cnt   <= '0;
    end else if (run) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      carry <= cell_cout;
      cnt   <= cnt + CW'(1);
    end
  end

  // Results move only on the edge that processes the MSB; carry still holds
  // the carry into the MSB there, which gives signed overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.sum      <= '0;
      bus.cout     <= 1'b0;
      bus.overflow <= 1'b0;
    end else if (run && last) begin
      bus.sum      <= psum_next;
      bus.cout     <= cell_cout;
      bus.overflow <= carry ^ cell_cout;
    end
  end

  assign bus.ready = (state != RUN);
  assign bus.busy  = run;
  assign bus.done  = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Randomised self-checking bench for serial_adder at WIDTH=8 and WIDTH=1,
// compared against plain integer addition.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   done_cyc = 0;
  logic [7:0] prev8 = 8'h00;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one 8-bit addition starting at a negedge; poke re-pulses start mid-run.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c,
                               input bit poke, input bit gap);
    logic [8:0] full;
    logic       exp_ovf;
    int         n;
    if (gap) begin
      @(negedge clk);
      checkOutput("done_one_cycle", bus8.done, 1'b0);
    end
    full    = {1'b0, a} + {1'b0, b} + {8'd0, c};
    exp_ovf = (a[7] == b[7]) && (full[7] != a[7]);
    bus8.a = a; bus8.b = b; bus8.cin = c; bus8.start = 1'b1;
    checkOutput("ready_before", bus8.ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
    checkOutput("ready_drop", bus8.ready, 1'b0);
    n = 0;
    while (!bus8.done && n < 40) begin
      bus8.start = poke && (n == 2 || n == 5);
      if (bus8.start) begin
        bus8.a = ~a; bus8.b = ~b;
      end
      if (n == 3 || n == 6) checkOutput("sum_held", bus8.sum, prev8);
      @(negedge clk);
      n++;
    end
    bus8.start = 1'b0;
    done_cyc = cyc;
    checkOutput("latency8", n, 8);
    checkOutput("sum8", bus8.sum, full[7:0]);
    checkOutput("cout8", bus8.cout, full[8]);
    checkOutput("ovf8", bus8.overflow, exp_ovf);
    checkOutput("ready_done", bus8.ready, 1'b1);
    prev8 = full[7:0];
  endtask

  task automatic runOne(input logic a, input logic b, input logic c);
    logic [1:0] full;
    int         n;
    @(negedge clk);
    full = {1'b0, a} + {1'b0, b} + {1'b0, c};
    bus1.a = a; bus1.b = b; bus1.cin = c; bus1.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.start = 1'b0;
    bus1.a = ~a; bus1.b = ~b; bus1.cin = ~c;
    n = 0;
    while (!bus1.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("latency1", n, 1);
    checkOutput("sum1", {bus1.cout, bus1.sum}, full);
    checkOutput("ovf1", bus1.overflow, c ^ full[1]);
  endtask

  initial begin
    int d1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", bus8.ready, 1'b1);
    checkOutput("rst_flags", {bus8.busy, bus8.done, bus8.cout, bus8.overflow}, 4'b0000);
    checkOutput("rst_sum", bus8.sum, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      runOne(v[2], v[1], v[0]);
    end

    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'h3C, 8'h4D, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++)
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1);

    applyStimulus(8'hC0, 8'h90, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    bus8.a = 8'h55; bus8.b = 8'h66; bus8.cin = 1'b1; bus8.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_sum", bus8.sum, 8'h00);
    checkOutput("arst_flags", {bus8.busy, bus8.done, bus8.cout, bus8.overflow}, 4'b0000);
    checkOutput("arst_ready", bus8.ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    prev8 = 8'h00;
    applyStimulus(8'h10, 8'h20, 1'b0, 1'b0, 1'b1);

    applyStimulus(8'h81, 8'h92, 1'b1, 1'b0, 1'b1);
    d1 = done_cyc;
    applyStimulus(8'h0F, 8'hF3, 1'b0, 1'b0, 1'b0);
    checkOutput("b2b_spacing", done_cyc - d1, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder: adds two WIDTH-bit operands plus carry-in over WIDTH clock cycles, processing one bit per cycle through a single full-adder cell and a carry flip-flop. It is the sequential, width-generic successor to the single-bit full adder. It targets area-constrained datapaths where one adder cell is reused across all bit positions, with a start/ready/done handshake.

## Interface
- WIDTH, 8: operand and result width in bits; legal range 1..64.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when ready=1.
- a  in  WIDTH  operand A; captured on the accepting edge.
- b  in  WIDTH  operand B; captured on the accepting edge.
- cin  in  1  carry-in; captured on the accepting edge.
- ready  out  1  high in IDLE and DONE; a new start is accepted.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse; result outputs are valid and updated.
- sum  out  WIDTH  registered result, held until the next completion.
- cout  out  1  registered carry-out of bit WIDTH-1.
- overflow  out  1  registered signed overflow (carry into MSB XOR carry out of MSB).

## Operation
- States: IDLE, RUN, DONE.
- IDLE: if start=1 at an edge:
  - load shift registers with a and b, and the carry flop with cin;
  - clear the bit counter; go to RUN.
- RUN, one bit per edge:
  - feed operand LSBs and the carry flop into the full-adder cell;
  - shift the sum bit into the MSB of the internal partial-sum register;
  - shift both operands right by 1; carry flop <= cell carry-out;
  - increment the counter.
- When the counter reaches WIDTH-1 at an edge, that edge processes the final bit and:
  - copies the partial sum to sum and the cell carry-out to cout;
  - sets overflow = carry flop (carry into MSB) XOR cell carry-out;
  - moves to DONE.
- DONE lasts exactly one cycle with done=1.
  - start=1 in DONE is accepted exactly as in IDLE: state goes to RUN.
  - Otherwise state goes to IDLE.
- start while busy=1 is ignored; operands are not re-captured.
- a, b and cin may change freely after the accepting edge.
- Counter width is $clog2(WIDTH) with a minimum of 1 bit.
- WIDTH=1: RUN lasts one cycle; overflow = cin XOR cout.
- Result registers (sum, cout, overflow) change only on the completion edge or on reset.
- Reset, including mid-operation:
  - IDLE; ready=1; busy=0; done=0; sum=0; cout=0; overflow=0;
  - internal registers and counter cleared;
  - the in-flight operation is discarded.

## Timing
- Edge E0 accepts start. Edges E1..EWIDTH process bits 0..WIDTH-1.
- done=1 during the cycle after edge EWIDTH.
- Latency from accepting edge to done: WIDTH cycles.
- Throughput with back-to-back starts: one result per WIDTH+1 cycles.
- ready drops the cycle after acceptance and rises together with done.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package adder_pkg holds:
  - the state typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - a WIDTH_MAX=64 constant for parameter checks.
- Sub-module fa_cell: a purely combinational one-bit full adder (a, b, cin -> s, cout). Instantiate it once.
- An elaboration-time check rejects WIDTH<1 or WIDTH>WIDTH_MAX.

## Test plan
- WIDTH=1: all 8 {a,b,cin} combinations stepped through in order -> {cout,sum} equals a+b+cin for each. done arrives 1 cycle after acceptance.
- WIDTH=8, a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, overflow=0. done is high exactly 8 cycles after the accepting edge.
- WIDTH=8, a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, overflow=1. Then a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1, overflow=0.
- Start pulsed again at cycles 2 and 5 of a RUN with different operands -> ignored. The first result is unchanged, and sum stays at the previous result until completion.
- rst asserted asynchronously mid-RUN (after 3 bits) -> all outputs read 0 immediately and ready=1. A following start with 8'h10+8'h20 -> sum=8'h30.
- Start held high in the DONE cycle -> second operation accepted with no IDLE cycle. Two done pulses are spaced 9 cycles apart.
